// File: rtl/seq_div_pkg.sv
// Shared types and constants for the 8/4 sequential restoring divider.
package seq_div_pkg;

    localparam int DIV_NW    = 8;
    localparam int DIV_HW    = 4;
    localparam int DIV_ITERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        FIN  = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_div8x4_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] pr_i,
    input  logic         bit_i,
    input  logic [W-1:0] v_i,
    output logic [W:0]   pr_o,
    output logic         q_o
);

    logic [W:0] t;

    always_comb begin
        t    = {pr_i, bit_i};
        q_o  = (t >= {1'b0, v_i});
        pr_o = q_o ? (t - {1'b0, v_i}) : t;
    end

endmodule

// File: rtl/seq_div8x4.sv
// Sequential NW/(NW/2) unsigned divider, one quotient bit per cycle.
// Optional early overflow / divide-by-zero detection under SEQ_DIV_OVF_CHECK_EN.
module seq_div8x4
    import seq_div_pkg::*;
#(
    parameter int NW = DIV_NW
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic [NW-1:0]     N,
    input  logic [NW/2-1:0]   V,
    output logic [NW/2-1:0]   Q,
    output logic [NW/2-1:0]   R,
    output logic              READY,
    output logic              OVF
);

    localparam int HW    = NW / 2;
    localparam int ITERS = DIV_ITERS * NW / DIV_NW;
    localparam int CW    = (ITERS > 2) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    div_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   n_q, n_d;
    logic [HW-1:0]   v_q, v_d;
    logic [HW:0]     pr_q, pr_d;
    logic [HW-1:0]   qs_q, qs_d;
    logic [HW-1:0]   q_q, q_d;
    logic [HW-1:0]   r_q, r_d;
    logic            ready_q;
`ifdef SEQ_DIV_OVF_CHECK_EN
    logic            ovf_q, ovf_d;
    logic            ovf_pend_q, ovf_pend_d;
`endif

    logic [HW:0]     step_pr;
    logic            step_q;
    // Only the low HW bits of the partial remainder feed the next step.
    logic            unused_pr_msb;
    assign unused_pr_msb = pr_q[HW];

    div_step #(.W(HW)) u_step (
        .pr_i  (pr_q[HW-1:0]),
        .bit_i (qs_q[HW-1]),
        .v_i   (v_q),
        .pr_o  (step_pr),
        .q_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        v_d     = v_q;
        pr_d    = pr_q;
        qs_d    = qs_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef SEQ_DIV_OVF_CHECK_EN
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
`endif
        if (START) begin
            state_d = LOAD;
            n_d     = N;
            v_d     = V;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    pr_d    = {1'b0, n_q[NW-1:HW]};
                    qs_d    = n_q[HW-1:0];
                    state_d = ITER;
`ifdef SEQ_DIV_OVF_CHECK_EN
                    ovf_pend_d = 1'b0;
                    // Quotient cannot fit (covers V=0): saturate and skip the iterations.
                    if (n_q[NW-1:HW] >= v_q) begin
                        qs_d       = '1;
                        pr_d       = '0;
                        ovf_pend_d = 1'b1;
                        state_d    = FIN;
                    end
`endif
                end
                ITER: begin
                    pr_d  = step_pr;
                    qs_d  = {qs_q[HW-2:0], step_q};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST)
                        state_d = FIN;
                end
                FIN: begin
                    q_d     = qs_q;
                    r_d     = pr_q[HW-1:0];
`ifdef SEQ_DIV_OVF_CHECK_EN
                    ovf_d   = ovf_pend_q;
`endif
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            v_q     <= '0;
            pr_q    <= '0;
            qs_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ready_q <= 1'b1;
`ifdef SEQ_DIV_OVF_CHECK_EN
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            v_q     <= v_d;
            pr_q    <= pr_d;
            qs_q    <= qs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ready_q <= (state_q == IDLE);
`ifdef SEQ_DIV_OVF_CHECK_EN
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
`endif
        end
    end

    assign Q     = q_q;
    assign R     = r_q;
    assign READY = ready_q;
`ifdef SEQ_DIV_OVF_CHECK_EN
    assign OVF   = ovf_q;
`else
    assign OVF   = 1'b0;
`endif

endmodule

// File: doc/seq_div8x4.md
SEQ_DIV8X4 -- requirements
Module: seq_div8x4

Interface
REQ-001 SHALL have parameter NW, default 8, meaning dividend width; divisor, quotient and remainder width is NW/2.
REQ-002 SHALL have port CK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port START, input, 1 bit: command strobe, sampled every rising edge of CK.
REQ-005 SHALL have port N, input, 8 bits: dividend (typically a product word P7..P0 from the shift-add multiplier).
REQ-006 SHALL have port V, input, 4 bits: divisor.
REQ-007 SHALL have port Q, output, 4 bits: quotient, registered.
REQ-008 SHALL have port R, output, 4 bits: remainder, registered.
REQ-009 SHALL have port READY, output, 1 bit: high while idle with results valid.
REQ-010 SHALL have port OVF, output, 1 bit: overflow or divide-by-zero flag, registered.

Function
REQ-011 SHALL implement an FSM with states IDLE, LOAD, ITER and FIN, driven by a 2-bit iteration counter CNT.
REQ-012 SHALL drive READY=1 only in IDLE; READY is a registered state decode.
REQ-013 SHALL, on START=1 in any state, capture N and V, clear CNT and enter LOAD; START while busy aborts and restarts the operation, with no result and no READY pulse for the aborted one.
REQ-014 SHALL, in LOAD, set the 5-bit partial remainder PR={0,N[7:4]} and the shift register QS=N[3:0], then enter ITER.
REQ-015 SHALL, in each ITER cycle, form T={PR[3:0],QS[3]}: if T>=V then PR=T-V and shift 1 into QS; otherwise PR=T and shift 0 into QS; then CNT increments.
REQ-016 SHALL leave ITER after the 4th iteration (CNT=3) and enter FIN.
REQ-017 SHALL, in FIN, load Q=QS and R=PR[3:0], then enter IDLE.
REQ-018 SHALL, with START held high, restart every cycle and never assert READY.
REQ-019 SHALL have a latency of exactly 7 edges from START high at edge t to READY=1 at edge t+7, with Q, R and OVF valid in that same cycle, where the edge sequence is LOAD at t+1, ITER at t+2 to t+5, FIN at t+6 and IDLE at t+7.
REQ-020 SHALL hold Q, R and OVF stable in IDLE until the next FIN or RST.
REQ-021 SHALL treat all arithmetic as unsigned, producing no negative intermediate in the compare/subtract.

Reset
REQ-022 SHALL, with RST=1 at a rising edge, force IDLE, CNT=0, Q=0, R=0, OVF=0 and READY=1 next cycle, overriding START.
REQ-023 SHALL, on RST mid-operation, discard the operation with no partial result visible.

Configuration
REQ-024 SHALL provide macro SEQ_DIV_OVF_CHECK_EN.
REQ-025 SHALL, when SEQ_DIV_OVF_CHECK_EN is defined, evaluate N[7:4]>=V in LOAD (this includes V=0); if true, go LOAD->FIN directly with Q=4'hF, R=4'h0 and OVF=1, giving READY at t+3.
REQ-026 SHALL, when SEQ_DIV_OVF_CHECK_EN is undefined, tie OVF to 0, always run 4 iterations, and return raw algorithm output; overflow operands then have no specified Q and R.

Structure
REQ-027 SHALL place the state enum (IDLE/LOAD/ITER/FIN), the width constants (8, 4) and the iteration count 4 in shared package seq_div_pkg.
REQ-028 SHALL implement one combinational sub-module div_step (inputs PR, next bit and V; outputs new PR and quotient bit), instantiated once in the FSM datapath.

Verification
REQ-029 SHALL cover: RST, then START with N=143, V=11 -> READY at t+7, Q=13, R=0, OVF=0.
REQ-030 SHALL cover: N=120, V=9 -> Q=13, R=3; then N=100, V=7 -> Q=14, R=2, with READY dropping at t+1 of the second START.
REQ-031 SHALL cover (with EN): N=255, V=15 and N=0x12, V=0 -> each gives OVF=1, Q=4'hF, R=0, READY at t+3; (without EN) OVF stays 0.
REQ-032 SHALL cover: START N=143, V=11, then START N=100, V=7 at t+3 -> no READY until t+10, then Q=14, R=2.
REQ-033 SHALL cover: RST=1 at t+4 during an operation -> next cycle READY=1, Q=0, R=0, OVF=0.
REQ-034 SHALL cover: an exhaustive sweep over all N and all V>0 with N[7:4]<V, each checked against N=Q*V+R with R<V.
